mac_node: RTL
=============

# mac_node

Parametrised sequential neural-network node. It streams N_INPUTS signed fixed-point (coefficient, data) pairs through one multiplier. It accumulates the products at full precision and applies a run-time-selectable activation. The result is presented on a valid/ready output port. It replaces the single-shot node inside the network layer, and layer control sequences one mac_node per neuron.

## Interface
- DATA_W, 16, width of coef/data/result words, signed two's complement
- FRAC_W, 8, fractional bits in every DATA_W word (Q(DATA_W-FRAC_W).FRAC_W)
- N_INPUTS, 64, number of pairs accumulated per evaluation (≥1)
- ACC_W, 40, accumulator width; must be ≥ 2*DATA_W + clog2(N_INPUTS), so the accumulator never wraps
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin evaluation; sampled only in IDLE
- act_sel  in  2  activation: 00 linear, 01 ReLU, 10 step, 11 linear; latched on accepted start
- in_valid  in  1  coef_in/data_in valid
- in_ready  out  1  node accepts a pair this cycle
- coef_in  in  DATA_W  coefficient
- data_in  in  DATA_W  data sample
- out_valid  out  1  node_out valid
- out_ready  in  1  downstream accepts node_out
- node_out  out  DATA_W  activated result
- ovf  out  1  result was saturated; qualified by out_valid
- busy  out  1  state != IDLE
- bias_in  in  DATA_W  bias, present only with MAC_NODE_BIAS_EN

## Operation
- FSM states are IDLE, ACC, ACT and OUT.
- IDLE → ACC on start=1. On that edge: act_sel latched, acc cleared (or loaded with bias, see Configuration), count cleared.
- In ACC, in_ready=1. Each cycle with in_valid&in_ready: acc += sign-extended (coef_in*data_in), the full 2*DATA_W product. Count increments.
- The pair accepted when count==N_INPUTS-1 moves the FSM to ACT. in_valid gaps stall without loss.
- In ACT, for one cycle:
  - r = acc >>> FRAC_W (arithmetic, floor truncation).
  - r saturates to the signed DATA_W range; ovf=1 if clamped.
  - The activation is applied and node_out/ovf are registered. FSM → OUT.
- Activations:
  - linear: r.
  - ReLU: r<0 ? 0 : r.
  - step: r>0 ? 1.0 (1<<FRAC_W) : 0. ovf still reflects saturation of r.
- In OUT, out_valid=1. node_out and ovf are held stable until out_valid&out_ready, then → IDLE.
- start is ignored outside IDLE. in_valid is ignored outside ACC, where in_ready=0.
- Reset values: in_ready=0, out_valid=0, node_out=0, ovf=0, busy=0, FSM=IDLE, acc=0, count=0.

## Timing
- With an accepted start at edge S, in_ready=1 from cycle S+1.
- With the last pair accepted at edge T, ACT occupies cycle T+1. out_valid and node_out are visible from T+2.
- Minimum evaluation is 1 (start) + N_INPUTS + 1 (ACT) + 1 (OUT handshake) cycles. Back-to-back: start may be asserted in the cycle after the OUT handshake.
- A handshake in the same cycle as out_valid rises is legal; out_valid is then high for exactly one cycle.
- rst mid-operation aborts immediately: outputs go to reset values asynchronously, and partial acc is discarded.
- start=1 together with in_valid=1 in IDLE: start is taken and the pair is not consumed.

## Configuration
- MAC_NODE_BIAS_EN defined: the bias_in port exists.
  - On an accepted start, acc loads sign-extended bias_in << FRAC_W.
  - The result is therefore bias + Σ coef*data.
- MAC_NODE_BIAS_EN undefined: no bias_in port, and acc clears to 0 on start.

## Test plan
- Basic MAC (DATA_W=16, FRAC_W=8, N_INPUTS=4, linear): 4× coef=0x0100, data=0x0100 → node_out=0x0400, ovf=0, out_valid at T+2.
- Negative with activations: 4× coef=0xFF00, data=0x0100 → linear gives 0xFC00; ReLU gives 0x0000; step gives 0x0000. Positive sum with step gives 0x0100.
- Saturation: 4× coef=0x7FFF, data=0x7FFF → node_out=0x7FFF, ovf=1. All coef=0x8000, data=0x7FFF → 0x8000, ovf=1.
- Flow control:
  - Random in_valid gaps give the same result as a gapless stream.
  - out_ready held low for 5 cycles: node_out is stable, and start pulses during OUT are ignored (busy=1).
- Reset: rst asserted after 2 of 4 pairs → out_valid=0, busy=0 at once. A fresh 4-pair run then gives the correct, uncorrupted result.
- MAC_NODE_BIAS_EN: bias_in=0x0200 plus the basic-MAC stimulus → node_out=0x0600.

Source files
------------

// File: rtl/mac_node.sv
// Sequential MAC neural-network node: streams N_INPUTS (coef, data) pairs through one
// multiplier, then applies saturation and an activation. Define MAC_NODE_BIAS_EN to add bias_in.
module mac_node #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int N_INPUTS = 64,
  parameter int ACC_W    = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        act_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] coef_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] node_out,
  output logic              ovf,
  output logic              busy
`ifdef MAC_NODE_BIAS_EN
  ,
  input  logic [DATA_W-1:0] bias_in
`endif
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] ACT  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [1:0] ACT_RELU = 2'b01;
  localparam logic [1:0] ACT_STEP = 2'b10;

  // Signed DATA_W limits expressed at accumulator width for the saturation compare.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] STEP_ONE = DATA_W'(1 << FRAC_W);

  logic [1:0]                 state;
  logic [1:0]                 act_q;
  logic [CNT_W-1:0]           count;
  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_init;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [DATA_W-1:0]   sat_val;
  logic [DATA_W-1:0]          act_val;
  logic                       sat_flag;

  assign prod     = $signed(coef_in) * $signed(data_in);
  assign prod_ext = ACC_W'(prod);
  assign shifted  = acc >>> FRAC_W;

`ifdef MAC_NODE_BIAS_EN
  assign acc_init = ACC_W'($signed(bias_in)) <<< FRAC_W;
`else
  assign acc_init = '0;
`endif

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  // Clamp the rescaled sum to DATA_W, then apply the latched activation to the clamped value.
  always_comb begin
    sat_flag = 1'b0;
    sat_val  = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_val  = SAT_MAX[DATA_W-1:0];
      sat_flag = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val  = SAT_MIN[DATA_W-1:0];
      sat_flag = 1'b1;
    end

    act_val = sat_val;
    case (act_q)
      ACT_RELU: if (sat_val < 0) act_val = '0;
      ACT_STEP: act_val = (sat_val > 0) ? STEP_ONE : '0;
      default:  act_val = sat_val;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      act_q    <= 2'b00;
      count    <= '0;
      acc      <= '0;
      node_out <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            act_q <= act_sel;
            acc   <= acc_init;
            count <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc <= acc + prod_ext;
            if (count == LAST) begin
              state <= ACT;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ACT: begin
          node_out <= act_val;
          ovf      <= sat_flag;
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
